fixed_p_std_seq_div: RTL and testbench
======================================

FIXED_P_STD_SEQ_DIV -- requirements
Module: fixed_p_std_seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32: total bit width of operands and results.
REQ-002 SHALL have parameter INT_WIDTH, default 8: integer bits of the unsigned fixed-point format.
REQ-003 SHALL have parameter FRACT_WIDTH, default 24: fraction bits; INT_WIDTH+FRACT_WIDTH SHALL equal WIDTH, else elaboration error.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port go  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port left  input  WIDTH  dividend, unsigned fixed-point.
REQ-008 SHALL have port right  input  WIDTH  divisor, unsigned fixed-point.
REQ-009 SHALL have port out_quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port out_remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL compute Q = floor((left << FRACT_WIDTH) / right) and R = (left << FRACT_WIDTH) mod right, unsigned.
REQ-013 SHALL output out_quotient = Q[WIDTH-1:0]; overflowing upper bits are discarded, no saturation.
REQ-014 SHALL use restoring shift-subtract, one quotient bit per cycle, WIDTH+FRACT_WIDTH iterations, MSB first.
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE -> RUN when go=1: latch left/right, clear iteration counter, clear working remainder.
REQ-017 RUN stays for exactly WIDTH+FRACT_WIDTH cycles, then -> DONE.
REQ-018 DONE SHALL last one cycle with done=1, out_quotient/out_remainder valid, then -> IDLE unconditionally.
REQ-019 Latency: go accepted in cycle 0 -> done=1 in cycle WIDTH+FRACT_WIDTH+1.
REQ-020 done SHALL be 0 in every state except DONE.
REQ-021 go in RUN or DONE SHALL be ignored; left/right changes after acceptance SHALL not affect the result.
REQ-022 go=1 in the IDLE cycle after DONE SHALL start a new operation.
REQ-023 Outputs SHALL hold the last result until the next DONE; they update only on entry to DONE.
REQ-024 Divide-by-zero (latched right=0): out_quotient all ones, out_remainder = latched left, same latency.

Reset
REQ-025 reset=1 SHALL force IDLE, done=0, out_quotient=0, out_remainder=0, counter=0 at the next edge.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; reset has priority over go.

Configuration
REQ-027 With macro FIXED_P_SEQ_DIV_ZERO_FLAG_EN defined, SHALL add output div_by_zero (1 bit), registered with the results, 1 iff latched right=0, reset 0, held like other results.
REQ-028 Without FIXED_P_SEQ_DIV_ZERO_FLAG_EN, port div_by_zero SHALL not exist; REQ-024 behaviour unchanged.

Verification (WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4)
REQ-029 left=0x30, right=0x20, go pulse in cycle 0 -> done=1 only in cycle 13, out_quotient=0x18, out_remainder=0x00.
REQ-030 left=0x10, right=0x30 -> out_quotient=0x05, out_remainder=0x10.
REQ-031 left=0x30, right=0x00 -> out_quotient=0xFF, out_remainder=0x30, div_by_zero=1 when macro defined.
REQ-032 left=0xF0, right=0x01 -> out_quotient=0x00 (truncated), out_remainder=0x00; then left=0x30, right=0x20 with go in RUN cycle 5 -> ignored, first result unchanged.
REQ-033 Start left=0x30, right=0x20; reset=1 in RUN cycle 6 -> no done pulse, outputs 0x00; new go next IDLE cycle -> correct result 13 cycles later.
REQ-034 go held high continuously -> back-to-back operations, done pulses every 14 cycles.

Source files
------------

// File: rtl/fixed_p_std_seq_div.sv
// fixed_p_std_seq_div: unsigned fixed-point sequential divider.
// Q = floor((left << FRACT_WIDTH) / right), R = (left << FRACT_WIDTH) mod right.
// Restoring shift-subtract, one quotient bit per cycle, WIDTH+FRACT_WIDTH cycles.
// Optional macro FIXED_P_SEQ_DIV_ZERO_FLAG_EN adds a registered div_by_zero output.
module fixed_p_std_seq_div #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
    output logic             div_by_zero,
`endif
    output logic             done
);

    localparam int N  = WIDTH + FRACT_WIDTH;
    localparam int CW = $clog2(N + 1);

    generate
        if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_format
            $error("fixed_p_std_seq_div: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic [WIDTH-1:0] rem;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [N-1:0]    shreg;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [N-1:0]     shreg_nxt;

    // One restoring step: bring down the next dividend bit and try to subtract.
    always_comb begin
        trial     = {rem, shreg[N-1]};
        fits      = (trial >= {1'b0, right_q});
        // When the subtraction happens the result is below right, so the
        // low WIDTH bits of the wrapped difference are exact.
        rem_nxt   = fits ? (trial[WIDTH-1:0] - right_q) : trial[WIDTH-1:0];
        shreg_nxt = {shreg[N-2:0], fits};
    end

    // Control FSM, datapath registers and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            left_q        <= '0;
            right_q       <= '0;
            rem           <= '0;
            shreg         <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
            div_by_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        left_q  <= left;
                        right_q <= right;
                        shreg   <= {left, {FRACT_WIDTH{1'b0}}};
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    shreg <= shreg_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        // A zero divisor gets a defined answer rather than the
                        // shift-subtract residue.
                        if (right_q == '0) begin
                            out_quotient  <= '1;
                            out_remainder <= left_q;
                        end else begin
                            out_quotient  <= shreg_nxt[WIDTH-1:0];
                            out_remainder <= rem_nxt;
                        end
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
                        div_by_zero <= (right_q == '0);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_p_std_seq_div.sv
// Directed bench for fixed_p_std_seq_div at WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4.
module tb_fixed_p_std_seq_div;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] left;
    logic [7:0] right;
    logic [7:0] out_quotient;
    logic [7:0] out_remainder;
    logic       done;
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
    logic       div_by_zero;
`endif

    int errors = 0;
    int checks = 0;

    fixed_p_std_seq_div #(.WIDTH(8), .INT_WIDTH(4), .FRACT_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
        .div_by_zero   (div_by_zero),
`endif
        .done          (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; drive and sample there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue go in cycle 0, watch cycles 1..16. Optionally inject a go with new
    // operands in go_cyc, or assert reset for one cycle in rst_cyc.
    task automatic op(input logic [7:0] l, input logic [7:0] r, input int go_cyc,
                      input int rst_cyc, output int first_done, output int pulses);
        first_done = -1;
        pulses     = 0;
        left  = l;
        right = r;
        go    = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            go    = 1'b0;
            reset = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = c;
            end
            if (c == go_cyc) begin
                go    = 1'b1;
                left  = 8'h30;
                right = 8'h20;
            end
            if (c == rst_cyc) reset = 1'b1;
        end
    endtask

    int fd, np;
    int dc[$];

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        left  = 8'h00;
        right = 8'h00;
        tick();
        tick();
        chk("rst_q", 32'(out_quotient), 32'h00);
        chk("rst_r", 32'(out_remainder), 32'h00);
        chk("rst_done", 32'(done), 32'h0);
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
        chk("rst_dbz", 32'(div_by_zero), 32'h0);
`endif
        reset = 1'b0;
        tick();

        // 3.0 / 2.0 = 1.5
        op(8'h30, 8'h20, 0, 0, fd, np);
        chk("basic_lat", 32'(fd), 32'd13);
        chk("basic_pulses", 32'(np), 32'd1);
        chk("basic_q", 32'(out_quotient), 32'h18);
        chk("basic_r", 32'(out_remainder), 32'h00);
        chk("basic_done_low", 32'(done), 32'h0);

        // 15.0 / 0.0625 = 240 -> truncated to 0x00; go in RUN cycle 5 ignored
        op(8'hF0, 8'h01, 5, 0, fd, np);
        chk("trunc_lat", 32'(fd), 32'd13);
        chk("trunc_pulses", 32'(np), 32'd1);
        chk("trunc_q", 32'(out_quotient), 32'h00);
        chk("trunc_r", 32'(out_remainder), 32'h00);
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
        chk("trunc_dbz", 32'(div_by_zero), 32'h0);
`endif

        // divide by zero
        op(8'h30, 8'h00, 0, 0, fd, np);
        chk("dz_lat", 32'(fd), 32'd13);
        chk("dz_q", 32'(out_quotient), 32'hFF);
        chk("dz_r", 32'(out_remainder), 32'h30);
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
        chk("dz_flag", 32'(div_by_zero), 32'h1);
`endif

        // 1.0 / 3.0 = 0x05 rem 0x10
        op(8'h10, 8'h30, 0, 0, fd, np);
        chk("third_lat", 32'(fd), 32'd13);
        chk("third_q", 32'(out_quotient), 32'h05);
        chk("third_r", 32'(out_remainder), 32'h10);
`ifdef FIXED_P_SEQ_DIV_ZERO_FLAG_EN
        chk("third_dbz", 32'(div_by_zero), 32'h0);
`endif

        // reset in RUN cycle 6 aborts with no done and clears results
        op(8'h30, 8'h20, 0, 6, fd, np);
        chk("abort_pulses", 32'(np), 32'd0);
        chk("abort_q", 32'(out_quotient), 32'h00);
        chk("abort_r", 32'(out_remainder), 32'h00);
        chk("abort_done", 32'(done), 32'h0);

        // fresh start after abort
        op(8'h30, 8'h20, 0, 0, fd, np);
        chk("restart_lat", 32'(fd), 32'd13);
        chk("restart_q", 32'(out_quotient), 32'h18);
        chk("restart_r", 32'(out_remainder), 32'h00);

        // go held high: done at 13, 27, 41
        left  = 8'h10;
        right = 8'h30;
        go    = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (done === 1'b1) begin
                dc.push_back(c);
                chk("b2b_q", 32'(out_quotient), 32'h05);
                chk("b2b_r", 32'(out_remainder), 32'h10);
            end
        end
        go = 1'b0;
        chk("b2b_count", 32'(dc.size()), 32'd3);
        if (dc.size() >= 3) begin
            chk("b2b_first", 32'(dc[0]), 32'd13);
            chk("b2b_gap1", 32'(dc[1] - dc[0]), 32'd14);
            chk("b2b_gap2", 32'(dc[2] - dc[1]), 32'd14);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
